// File: rtl/pdu_dma_fetch.sv
// Fetches dma_size flits from the PDU ring buffer and streams them sop/eop-framed; dma_start@T -> out_valid@T+4.
// out_ready backpressure is absorbed by a skid FIFO; reads are only issued while FIFO + in-flight reads fit.
module pdu_dma_fetch #(
    parameter int PDU_DEPTH     = 512,
    parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
    parameter int APP_IDX_WIDTH = 5,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dma_start,
    input  logic [PDU_AWIDTH-1:0]    dma_size,
    input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
    input  logic [APP_IDX_WIDTH-1:0] dma_queue,
    output logic                     dma_done,
    output logic [PDU_AWIDTH-1:0]    rd_addr,
    output logic                     rd_en,
    input  logic                     rd_valid,
    input  logic [511:0]             rd_data,
    output logic [511:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [APP_IDX_WIDTH-1:0] out_queue,
    output logic                     busy,
    output logic                     err_overlap
);

    localparam int AW = PDU_AWIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            base_q, base_d;
    logic [AW-1:0]            size_q, size_d;
    logic [AW-1:0]            issued_q, issued_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [AW-1:0]            rd_addr_q, rd_addr_d;
    logic [APP_IDX_WIDTH-1:0] queue_q, queue_d;
    logic                     rd_en_q, rd_en_d;
    logic [1:0]               inflight_q, inflight_d;
    logic [1:0]               done_cnt_q, done_cnt_d;
    logic                     err_q, err_d;

    logic [511:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q;

    logic                     push, pop, fifo_vld, last_flit;
    logic [OW-1:0]            occ;

    assign push      = rd_valid && (inflight_q != 2'd0);
    assign fifo_vld  = (count_q != '0);
    assign pop       = fifo_vld && out_ready;
    assign last_flit = (idx_q == size_q - AW'(1));
    // Slots committed after this edge: stored flits plus every read still on its way back.
    assign occ       = OW'(count_q) + OW'(inflight_q) + OW'(rd_en_q) - OW'(pop);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        size_d     = size_q;
        issued_d   = issued_q;
        idx_d      = pop ? idx_q + AW'(1) : idx_q;
        rd_addr_d  = rd_addr_q;
        queue_d    = queue_q;
        rd_en_d    = 1'b0;
        done_cnt_d = done_cnt_q;
        err_d      = err_q | (dma_start && (state_q != IDLE));
        case ({rd_en_q, push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            IDLE: begin
                if (dma_start) begin
                    base_d     = dma_base_addr;
                    size_d     = dma_size;
                    queue_d    = dma_queue;
                    idx_d      = '0;
                    issued_d   = '0;
                    done_cnt_d = 2'd0;
                    if (dma_size == '0) begin
                        state_d = DONE;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = dma_base_addr;
                        issued_d  = AW'(1);
                        state_d   = (dma_size == AW'(1)) ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if ((issued_q != size_q) && (occ < OW'(FIFO_DEPTH))) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + issued_q;
                    issued_d  = issued_q + AW'(1);
                    if (issued_q + AW'(1) == size_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_flit) begin
                    state_d    = DONE;
                    done_cnt_d = 2'd0;
                end
            end
            DONE: begin
                done_cnt_d = done_cnt_q + 2'd1;
                if (done_cnt_q == 2'd2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            size_q     <= '0;
            issued_q   <= '0;
            idx_q      <= '0;
            rd_addr_q  <= '0;
            queue_q    <= '0;
            rd_en_q    <= 1'b0;
            inflight_q <= 2'd0;
            done_cnt_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            size_q     <= size_d;
            issued_q   <= issued_d;
            idx_q      <= idx_d;
            rd_addr_q  <= rd_addr_d;
            queue_q    <= queue_d;
            rd_en_q    <= rd_en_d;
            inflight_q <= inflight_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; out_data is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && (count_q == CW'(FIFO_DEPTH))));
    end

    assign out_valid   = fifo_vld;
    assign out_data    = fifo_vld ? mem[rd_ptr_q] : '0;
    assign out_sop     = fifo_vld && (idx_q == '0);
    assign out_eop     = fifo_vld && last_flit;
    assign out_queue   = queue_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign busy        = (state_q != IDLE);
    assign dma_done    = (state_q == DONE) && (done_cnt_q == 2'd2);
    assign err_overlap = err_q;

endmodule

// File: tb/tb_pdu_dma_fetch.sv
// Directed bench for pdu_dma_fetch with a 2-cycle PDU read-port model and an output/done monitor.
module tb_pdu_dma_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         dma_start;
    logic [8:0]   dma_size;
    logic [8:0]   dma_base_addr;
    logic [4:0]   dma_queue;
    logic         dma_done;
    logic [8:0]   rd_addr;
    logic         rd_en;
    logic         rd_valid;
    logic [511:0] rd_data;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic [4:0]   out_queue;
    logic         busy;
    logic         err_overlap;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           cyc;
        logic [511:0] d;
        logic         sop;
        logic         eop;
        logic [4:0]   q;
    } flit_t;

    flit_t      flits[$];
    int         rd_cyc[$];
    logic [8:0] rd_adr[$];
    int         done_cyc[$];
    int         rd_total = 0;
    int         pop_total = 0;
    int         max_out = 0;

    logic       v1 = 1'b0, v2 = 1'b0;
    logic [8:0] a1 = '0, a2 = '0;

    pdu_dma_fetch dut (
        .clk(clk), .rst(rst), .dma_start(dma_start), .dma_size(dma_size),
        .dma_base_addr(dma_base_addr), .dma_queue(dma_queue), .dma_done(dma_done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue),
        .busy(busy), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] pdu_word(input logic [8:0] a);
        return {16{23'h5A5A5A, a}};
    endfunction

    // PDU buffer model: data is visible at the second rising edge after the one that saw rd_en.
    always @(negedge clk) begin
        rd_valid = v2;
        rd_data  = pdu_word(a2);
        v2 = v1;
        a2 = a1;
        v1 = rd_en;
        a1 = rd_addr;
    end

    always @(negedge clk) begin
        flit_t f;
        if (rd_en) begin
            rd_cyc.push_back(cyc);
            rd_adr.push_back(rd_addr);
            rd_total++;
            if (rd_total - pop_total > max_out) max_out = rd_total - pop_total;
        end
        if (out_valid && out_ready) begin
            f.cyc = cyc; f.d = out_data; f.sop = out_sop; f.eop = out_eop; f.q = out_queue;
            flits.push_back(f);
            pop_total++;
        end
        if (dma_done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        flits.delete(); rd_cyc.delete(); rd_adr.delete(); done_cyc.delete();
        rd_total = 0; pop_total = 0; max_out = 0;
    endtask

    task automatic start(input logic [8:0] sz, input logic [8:0] base, input logic [4:0] q, output int t);
        clear_logs();
        dma_start = 1'b1; dma_size = sz; dma_base_addr = base; dma_queue = q;
        t = cyc;
        step();
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        for (int i = 0; i < maxc && done_cyc.size() == 0; i++) step();
        chk({tag, " done_seen"}, done_cyc.size() != 0, 1);
        step(); step();
    endtask

    task automatic check_stream(input string tag, input int n, input logic [8:0] base,
                                input logic [4:0] q, input int t0, input bit timed);
        logic [8:0] a;
        chk({tag, " n_reads"}, rd_adr.size(), n);
        chk({tag, " n_flits"}, flits.size(), n);
        chk({tag, " n_done"}, done_cyc.size(), 1);
        for (int i = 0; i < n && i < flits.size() && i < rd_adr.size(); i++) begin
            a = base + 9'(i);
            chk($sformatf("%s rd_addr[%0d]", tag, i), rd_adr[i], a);
            chk($sformatf("%s data[%0d]", tag, i), flits[i].d, pdu_word(a));
            chk($sformatf("%s sop[%0d]", tag, i), flits[i].sop, i == 0);
            chk($sformatf("%s eop[%0d]", tag, i), flits[i].eop, i == n - 1);
            chk($sformatf("%s queue[%0d]", tag, i), flits[i].q, q);
            if (timed) begin
                chk($sformatf("%s rd_cyc[%0d]", tag, i), rd_cyc[i], t0 + 1 + i);
                chk($sformatf("%s flit_cyc[%0d]", tag, i), flits[i].cyc, t0 + 4 + i);
            end
        end
    endtask

    initial begin
        int t;
        rst = 1'b1; dma_start = 1'b0; dma_size = '0; dma_base_addr = '0;
        dma_queue = '0; out_ready = 1'b1;
        step(); step();

        chk("rst out_valid", out_valid, 0);
        chk("rst rd_en", rd_en, 0);
        chk("rst busy", busy, 0);
        chk("rst dma_done", dma_done, 0);
        chk("rst err_overlap", err_overlap, 0);
        rst = 1'b0;
        step(); step();

        // 1: single flit, sop and eop together
        start(9'd1, 9'd10, 5'd3, t);
        chk("t1 busy", busy, 1);
        wait_done("t1", 40);
        check_stream("t1", 1, 9'd10, 5'd3, t, 1'b1);
        if (done_cyc.size() != 0) chk("t1 done_cyc", done_cyc[0], t + 7);
        chk("t1 busy_after", busy, 0);
        chk("t1 err_overlap", err_overlap, 0);

        // 2: address wrap 508..511,0..3, back-to-back flits
        start(9'd8, 9'd508, 5'd17, t);
        wait_done("t2", 60);
        check_stream("t2", 8, 9'd508, 5'd17, t, 1'b1);
        if (done_cyc.size() != 0) chk("t2 done_cyc", done_cyc[0], t + 14);

        // 3: out_ready high one cycle in four
        start(9'd16, 9'd100, 5'd7, t);
        for (int i = 0; i < 300 && done_cyc.size() == 0; i++) begin
            out_ready = (cyc % 4 == 0);
            step();
        end
        out_ready = 1'b1;
        wait_done("t3", 10);
        check_stream("t3", 16, 9'd100, 5'd7, t, 1'b0);
        chk("t3 max_outstanding", max_out, 4);

        // 4: zero-length request
        start(9'd0, 9'd40, 5'd2, t);
        chk("t4 busy", busy, 1);
        wait_done("t4", 20);
        chk("t4 n_reads", rd_adr.size(), 0);
        chk("t4 n_flits", flits.size(), 0);
        if (done_cyc.size() != 0) chk("t4 done_cyc", done_cyc[0], t + 3);

        // 5: overlapping start during FETCH is dropped
        start(9'd6, 9'd0, 5'd9, t);
        dma_start = 1'b1; dma_size = 9'd3; dma_base_addr = 9'd200; dma_queue = 5'd1;
        step();
        dma_start = 1'b0;
        chk("t5 err_overlap", err_overlap, 1);
        wait_done("t5", 60);
        check_stream("t5", 6, 9'd0, 5'd9, t, 1'b1);
        chk("t5 err_sticky", err_overlap, 1);

        // 6: reset in the middle of a 10-flit request
        start(9'd10, 9'd50, 5'd12, t);
        for (int i = 0; i < 50 && flits.size() < 3; i++) step();
        chk("t6 three_flits", flits.size() >= 3, 1);
        rst = 1'b1;
        #1;
        chk("t6 rst out_valid", out_valid, 0);
        chk("t6 rst out_data", out_data, 0);
        chk("t6 rst out_sop", out_sop, 0);
        chk("t6 rst out_eop", out_eop, 0);
        chk("t6 rst out_queue", out_queue, 0);
        chk("t6 rst rd_en", rd_en, 0);
        chk("t6 rst rd_addr", rd_addr, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst err_overlap", err_overlap, 0);
        clear_logs();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t6 no_done", done_cyc.size(), 0);
        chk("t6 no_flits", flits.size(), 0);
        start(9'd2, 9'd20, 5'd1, t);
        wait_done("t6b", 40);
        check_stream("t6b", 2, 9'd20, 5'd1, t, 1'b1);
        if (done_cyc.size() != 0) chk("t6b done_cyc", done_cyc[0], t + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
